// File: rtl/cqf_pkg.sv
// Shared constants for the CQF metadata scheduler: default widths, the TS marker bit
// and the queue indices used by the top level.
package cqf_pkg;

    localparam int unsigned DEF_MD_W    = 24;
    localparam int unsigned DEF_Q_DEPTH = 32;
    localparam int unsigned TS_BIT      = DEF_MD_W - 1;

    typedef logic [1:0] q_idx_t;

    localparam q_idx_t Q_TS0 = 2'd0;
    localparam q_idx_t Q_TS1 = 2'd1;
    localparam q_idx_t Q_BE  = 2'd2;

endpackage

// File: rtl/cqf_md_fifo.sv
// Register-array metadata FIFO with first-word-fall-through read and a registered 6-bit
// occupancy count. A push while full is accepted only alongside a pop.
module cqf_md_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_accept,
    output logic [5:0]       o_used
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [5:0]       r_used;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_used == 6'(DEPTH));
    assign o_empty   = (r_used == 6'd0);
    assign o_used    = r_used;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_accept  = w_do_push;

    // Storage needs no reset: contents are only visible while used > 0.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_used <= r_used + 6'd1;
                2'b01:   r_used <= r_used - 6'd1;
                default: r_used <= r_used;
            endcase
        end
    end

endmodule

// File: rtl/cqf_sched.sv
// CQF output scheduler: steers TS metadata into ping-pong queues by slot flag, BE into a
// third queue, and releases them with strict TS-first priority plus traffic counters.
module cqf_sched
    import cqf_pkg::*;
#(
    parameter int unsigned MD_W    = DEF_MD_W,
    parameter int unsigned Q_DEPTH = DEF_Q_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [MD_W-1:0] in_md,
    input  logic            in_md_wr,
    input  logic            time_slot_flag,
    input  logic            out_md_rdy,
    output logic [MD_W-1:0] out_md,
    output logic            out_md_wr,
    output logic [5:0]      q0_used_cnt,
    output logic [5:0]      q1_used_cnt,
    output logic [5:0]      q2_used_cnt,
    output logic [63:0]     mdin_cnt,
    output logic [63:0]     mdout_cnt,
    output logic [63:0]     discard_cnt,
    output logic [31:0]     overrun_cnt
);

    logic [MD_W-1:0] w_dout [3];
    logic [5:0]      w_used [3];
    logic [2:0]      w_push;
    logic [2:0]      w_pop;
    logic [2:0]      w_full;
    logic [2:0]      w_empty;
    logic [2:0]      w_accept;

    q_idx_t          w_rx_q;
    q_idx_t          w_tx_q;
    q_idx_t          w_old_tx_q;
    logic            w_pop_any;
    logic [MD_W-1:0] w_pop_md;
    logic            w_flip;
    logic            w_overrun;
    logic            w_enq_ok;
    logic            w_enq_drop;

    logic            r_flag;
    logic [MD_W-1:0] r_out_md;
    logic            r_out_wr;
    logic [63:0]     r_mdin_cnt;
    logic [63:0]     r_mdout_cnt;
    logic [63:0]     r_discard_cnt;
    logic [31:0]     r_overrun_cnt;

    for (genvar g = 0; g < 3; g++) begin : g_q
        cqf_md_fifo #(
            .WIDTH (MD_W),
            .DEPTH (Q_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_push   (w_push[g]),
            .i_din    (in_md),
            .i_pop    (w_pop[g]),
            .o_dout   (w_dout[g]),
            .o_full   (w_full[g]),
            .o_empty  (w_empty[g]),
            .o_accept (w_accept[g]),
            .o_used   (w_used[g])
        );
    end

    // Roles follow the live flag so the flip cycle already uses the new assignment.
    always_comb begin
        w_rx_q     = time_slot_flag ? Q_TS1 : Q_TS0;
        w_tx_q     = time_slot_flag ? Q_TS0 : Q_TS1;
        w_old_tx_q = r_flag ? Q_TS0 : Q_TS1;

        w_push = '0;
        if (in_md_wr) begin
            if (in_md[MD_W-1]) begin
                w_push[w_rx_q] = 1'b1;
            end else begin
                w_push[Q_BE] = 1'b1;
            end
        end

        w_pop     = '0;
        w_pop_any = 1'b0;
        w_pop_md  = '0;
        if (out_md_rdy) begin
            if (!w_empty[w_tx_q]) begin
                w_pop[w_tx_q] = 1'b1;
                w_pop_any     = 1'b1;
                w_pop_md      = w_dout[w_tx_q];
            end else if (!w_empty[Q_BE]) begin
                w_pop[Q_BE] = 1'b1;
                w_pop_any   = 1'b1;
                w_pop_md    = w_dout[Q_BE];
            end
        end

        w_flip     = (r_flag != time_slot_flag);
        w_overrun  = w_flip & ~w_empty[w_old_tx_q];
        w_enq_ok   = |w_accept;
        w_enq_drop = in_md_wr & ~w_enq_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag        <= 1'b0;
            r_out_md      <= '0;
            r_out_wr      <= 1'b0;
            r_mdin_cnt    <= '0;
            r_mdout_cnt   <= '0;
            r_discard_cnt <= '0;
            r_overrun_cnt <= '0;
        end else begin
            r_flag   <= time_slot_flag;
            r_out_wr <= w_pop_any;
            if (w_pop_any) begin
                r_out_md    <= w_pop_md;
                r_mdout_cnt <= r_mdout_cnt + 64'd1;
            end
            if (w_enq_ok) begin
                r_mdin_cnt <= r_mdin_cnt + 64'd1;
            end
            if (w_enq_drop) begin
                r_discard_cnt <= r_discard_cnt + 64'd1;
            end
            if (w_overrun) begin
                r_overrun_cnt <= r_overrun_cnt + 32'd1;
            end
        end
    end

    assign out_md      = r_out_md;
    assign out_md_wr   = r_out_wr;
    assign q0_used_cnt = w_used[Q_TS0];
    assign q1_used_cnt = w_used[Q_TS1];
    assign q2_used_cnt = w_used[Q_BE];
    assign mdin_cnt    = r_mdin_cnt;
    assign mdout_cnt   = r_mdout_cnt;
    assign discard_cnt = r_discard_cnt;
    assign overrun_cnt = r_overrun_cnt;

endmodule
